mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (fetch) and the MEM stage (load/store)
//  of the 5-stage riscv_cpu. One transaction at a time, fixed memory latency, DM-first priority with a
//  starvation guard for IF. Branch/jump flush kills an in-flight fetch response.
// PARAMETERS
//  XLEN          32   data width; byte-enable width is XLEN/8
//  ADDR_W        12   byte-address width (4096-byte memory)
//  MEM_LATENCY   2    cycles from mem_req to valid mem_rdata; legal range >=1
//  STARVE_LIMIT  4    consecutive DM wins over a waiting IF before IF is forced through; >=1
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  if_req_valid  in   1        fetch request
//  if_req_ready  out  1        fetch accepted when valid&ready
//  if_req_addr   in   ADDR_W   fetch byte address, word aligned
//  if_flush      in   1        kill in-flight/just-granted fetch response (branch_taken/jump)
//  if_rsp_valid  out  1        one-cycle pulse: fetch data valid
//  if_rsp_data   out  XLEN     fetched instruction
//  dm_req_valid  in   1        load/store request
//  dm_req_ready  out  1        load/store accepted when valid&ready
//  dm_req_addr   in   ADDR_W   data byte address
//  dm_req_we     in   1        1=store, 0=load
//  dm_req_wdata  in   XLEN     store data
//  dm_req_be     in   XLEN/8   store byte enables
//  dm_rsp_valid  out  1        one-cycle pulse: load data / store completion
//  dm_rsp_rdata  out  XLEN     load data; 0 for stores
//  mem_req       out  1        one-cycle memory access strobe
//  mem_addr      out  ADDR_W   granted address
//  mem_we        out  1        granted write enable (0 for IF)
//  mem_wdata     out  XLEN     granted write data (0 for IF)
//  mem_be        out  XLEN/8   granted byte enables ('1 for IF and loads)
//  mem_rdata     in   XLEN     read data, valid exactly MEM_LATENCY cycles after mem_req
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, owner NONE, counters 0, killed flag 0; all outputs 0 while in reset.
//  - FSM: IDLE -> WAIT on any grant; WAIT loads lat_cnt=MEM_LATENCY-1, decrements each cycle.
//    Cycle with WAIT&lat_cnt==0 is the response cycle: owner's rsp_valid=1, rsp data = mem_rdata
//    (dm_rsp_rdata=0 for stores). The same cycle is grant-eligible: new grant -> stay WAIT, else -> IDLE.
//  - Grant-eligible: IDLE, or response cycle. Exactly one req_ready high per eligible cycle, only for a
//    requester with valid=1. ready may depend combinationally on valid; requesters must not make valid
//    depend on ready. Request fields are sampled only in the handshake cycle.
//  - Grant cycle: mem_req=1, mem_* driven from winner; otherwise mem_* = 0. Throughput: one txn per
//    MEM_LATENCY cycles; MEM_LATENCY=1 gives one per cycle.
//  - Priority: DM wins when both valid, unless starve_cnt==STARVE_LIMIT, then IF wins. starve_cnt
//    increments on each DM grant with if_req_valid=1, clears on IF grant or if_req_valid=0; saturates.
//  - Flush: if_flush=1 in grant cycle or any WAIT cycle of an IF txn (incl. response cycle) sets killed;
//    killed txn gives no if_rsp_valid. killed clears on next grant. No effect on DM txns or on the
//    IF request granted in the same response cycle when if_flush is not re-asserted.
//  - Reset mid-transaction: txn dropped, no response after release; late mem_rdata ignored.
//  - Address/width: addresses passed unchanged; no alignment check; no arithmetic.
// STRUCTURE
//  - riscv_pkg: arb_state_e {ARB_IDLE, ARB_WAIT}, arb_owner_e {OWN_NONE, OWN_IF, OWN_DM}.
//  - One sub-module: mem_arb_starve_guard (saturating starve counter + force_if output).
//  - Latency counter width $clog2(MEM_LATENCY+1).
// TESTING  (MEM_LATENCY=2, STARVE_LIMIT=4, grant at cycle 0 unless noted)
//  1 IF only: addr 0x010, mem holds 0x00A00093 -> mem_req cyc0; if_rsp_valid cyc2 data 0x00A00093; ready cyc2.
//  2 IF+DM together: DM lw 0x100 (=0x5) -> DM granted cyc0, IF cyc2; dm_rsp 0x5 cyc2, if_rsp cyc4.
//  3 Both held valid -> DM grants cyc0,2,4,6; IF forced cyc8; DM cyc10; starve_cnt back to 0.
//  4 IF granted cyc0, if_flush cyc1 -> no if_rsp_valid cyc2; new IF fetch accepted cyc2, rsp cyc4.
//  5 DM sw 0x0000000A @0x200 be=4'hF -> mem_we=1, mem_wdata=0xA cyc0; dm_rsp_valid cyc2 rdata 0; lw 0x200 -> 0xA.
//  6 rst_n=0 at cyc1 of DM load -> all outputs 0 at once; after release no dm_rsp_valid, IDLE, IF accepted.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory port arbiter: FSM state and transaction owner.
package riscv_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive DM wins over a waiting fetch and forces the fetch through at the limit.
module mem_arb_starve_guard #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_valid,
    input  logic if_grant,
    input  logic dm_grant,
    output logic force_if
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // A fetch that stops asking is no longer being starved, so the count restarts.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_grant || !if_req_valid) begin
            starve_cnt_d = '0;
        end else if (dm_grant && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_if = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and load/store.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 12,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [XLEN-1:0]     if_rsp_data,
    input  logic                dm_req_valid,
    output logic                dm_req_ready,
    input  logic [ADDR_W-1:0]   dm_req_addr,
    input  logic                dm_req_we,
    input  logic [XLEN-1:0]     dm_req_wdata,
    input  logic [XLEN/8-1:0]   dm_req_be,
    output logic                dm_rsp_valid,
    output logic [XLEN-1:0]     dm_rsp_rdata,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

    arb_state_e       state_q;
    arb_owner_e       owner_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             killed_q;
    logic             store_q;

    logic rsp_cycle;
    logic eligible;
    logic force_if;
    logic grant_if;
    logic grant_dm;

    assign rsp_cycle = (state_q == ARB_WAIT) && (lat_cnt_q == '0);
    // Gating with rst_n keeps every combinational output quiet while reset is held.
    assign eligible  = rst_n && ((state_q == ARB_IDLE) || rsp_cycle);
    assign grant_dm  = eligible && dm_req_valid && !(if_req_valid && force_if);
    assign grant_if  = eligible && if_req_valid && !grant_dm;

    mem_arb_starve_guard #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_guard (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_valid(if_req_valid),
        .if_grant    (grant_if),
        .dm_grant    (grant_dm),
        .force_if    (force_if)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            lat_cnt_q <= '0;
            killed_q  <= 1'b0;
            store_q   <= 1'b0;
        end else if (grant_if || grant_dm) begin
            state_q   <= ARB_WAIT;
            owner_q   <= grant_if ? OWN_IF : OWN_DM;
            lat_cnt_q <= LAT_INIT;
            killed_q  <= grant_if && if_flush;
            store_q   <= grant_dm && dm_req_we;
        end else if (rsp_cycle) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            killed_q  <= 1'b0;
            store_q   <= 1'b0;
        end else if (state_q == ARB_WAIT) begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            if ((owner_q == OWN_IF) && if_flush) begin
                killed_q <= 1'b1;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;

    assign mem_req   = grant_if || grant_dm;
    assign mem_addr  = grant_dm ? dm_req_addr : (grant_if ? if_req_addr : '0);
    assign mem_we    = grant_dm && dm_req_we;
    assign mem_wdata = (grant_dm && dm_req_we) ? dm_req_wdata : '0;
    assign mem_be    = grant_dm ? (dm_req_we ? dm_req_be : '1) : (grant_if ? '1 : '0);

    // A flush arriving in the response cycle itself still suppresses the fetch data.
    assign if_rsp_valid = rsp_cycle && (owner_q == OWN_IF) && !killed_q && !if_flush;
    assign dm_rsp_valid = rsp_cycle && (owner_q == OWN_DM);
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    assign dm_rsp_rdata = (dm_rsp_valid && !store_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a two-cycle-latency word memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [11:0] if_req_addr;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [11:0] dm_req_addr;
    logic        dm_req_we;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] memArray [0:1023];
    logic [31:0] pipeData0, pipeData1;
    logic        pipeVld0, pipeVld1;

    mem_port_arbiter #(
        .XLEN(32), .ADDR_W(12), .MEM_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_we(dm_req_we), .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: writes land at the strobe edge, read data appears two cycles after the strobe.
    always @(posedge clk) begin
        if (mem_req) begin
            pipeData0 <= memArray[mem_addr[11:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) memArray[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        pipeVld0  <= mem_req;
        pipeData1 <= pipeData0;
        pipeVld1  <= pipeVld0;
    end

    assign mem_rdata = pipeVld1 ? pipeData1 : 32'hDEADBEEF;

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's request inputs and lets combinational outputs settle.
    task automatic applyStimulus(input logic ifV, input logic [11:0] ifA, input logic flush,
                                 input logic dmV, input logic [11:0] dmA, input logic we,
                                 input logic [31:0] wd, input logic [3:0] be);
        if_req_valid = ifV;
        if_req_addr  = ifA;
        if_flush     = flush;
        dm_req_valid = dmV;
        dm_req_addr  = dmA;
        dm_req_we    = we;
        dm_req_wdata = wd;
        dm_req_be    = be;
        #1;
    endtask

    // Advances to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            stepCycle();
            applyStimulus(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        end
    endtask

    // Every output should read zero while reset is asserted, even with requests pending.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_if_ready"}, {31'b0, if_req_ready}, 32'h0);
        checkOutput({tag, "_dm_ready"}, {31'b0, dm_req_ready}, 32'h0);
        checkOutput({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        checkOutput({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'h0);
        checkOutput({tag, "_mem_be"}, {28'b0, mem_be}, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_if_rsp"}, {31'b0, if_rsp_valid}, 32'h0);
        checkOutput({tag, "_dm_rsp"}, {31'b0, dm_rsp_valid}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) memArray[i] = 32'h0;
        memArray[12'h010 >> 2] = 32'h00A00093;
        memArray[12'h014 >> 2] = 32'h00100113;
        memArray[12'h100 >> 2] = 32'h00000005;
        memArray[12'h200 >> 2] = 32'h12345678;
        pipeData0 = 32'h0; pipeData1 = 32'h0; pipeVld0 = 1'b0; pipeVld1 = 1'b0;

        rst_n = 1'b0;
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b1, 12'h100, 1'b0, 32'h0, 4'hF);
        #1;
        checkAllZero("reset");
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        idleCycles(2);

        $display("[TB] IF-only fetch");
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t1_if_ready", {31'b0, if_req_ready}, 32'h1);
        checkOutput("t1_dm_ready", {31'b0, dm_req_ready}, 32'h0);
        checkOutput("t1_mem_req", {31'b0, mem_req}, 32'h1);
        checkOutput("t1_mem_addr", {20'b0, mem_addr}, 32'h010);
        checkOutput("t1_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("t1_mem_be", {28'b0, mem_be}, 32'hF);
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t1_busy_ready", {31'b0, if_req_ready}, 32'h0);
        checkOutput("t1_busy_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("t1_early_rsp", {31'b0, if_rsp_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 12'h014, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t1_rsp_valid", {31'b0, if_rsp_valid}, 32'h1);
        checkOutput("t1_rsp_data", if_rsp_data, 32'h00A00093);
        checkOutput("t1_ready_cyc2", {31'b0, if_req_ready}, 32'h1);
        idleCycles(2);
        checkOutput("t1_rsp2_valid", {31'b0, if_rsp_valid}, 32'h1);
        checkOutput("t1_rsp2_data", if_rsp_data, 32'h00100113);
        idleCycles(2);

        $display("[TB] IF and DM together");
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b1, 12'h100, 1'b0, 32'h0, 4'h0);
        checkOutput("t2_dm_ready", {31'b0, dm_req_ready}, 32'h1);
        checkOutput("t2_if_ready", {31'b0, if_req_ready}, 32'h0);
        checkOutput("t2_mem_addr", {20'b0, mem_addr}, 32'h100);
        checkOutput("t2_mem_be", {28'b0, mem_be}, 32'hF);
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t2_if_wait", {31'b0, if_req_ready}, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t2_dm_rsp", {31'b0, dm_rsp_valid}, 32'h1);
        checkOutput("t2_dm_rdata", dm_rsp_rdata, 32'h5);
        checkOutput("t2_if_ready_cyc2", {31'b0, if_req_ready}, 32'h1);
        checkOutput("t2_if_mem_addr", {20'b0, mem_addr}, 32'h010);
        idleCycles(2);
        checkOutput("t2_if_rsp", {31'b0, if_rsp_valid}, 32'h1);
        checkOutput("t2_if_data", if_rsp_data, 32'h00A00093);
        checkOutput("t2_no_dm_rsp", {31'b0, dm_rsp_valid}, 32'h0);
        idleCycles(2);

        $display("[TB] Starvation guard");
        for (int c = 0; c < 12; c++) begin
            stepCycle();
            applyStimulus(1'b1, 12'h010, 1'b0, 1'b1, 12'h100, 1'b0, 32'h0, 4'h0);
            checkOutput($sformatf("t3_dm_ready_c%0d", c), {31'b0, dm_req_ready},
                        {31'b0, (c % 2 == 0) && (c != 8)});
            checkOutput($sformatf("t3_if_ready_c%0d", c), {31'b0, if_req_ready}, {31'b0, c == 8});
            checkOutput($sformatf("t3_dm_rsp_c%0d", c), {31'b0, dm_rsp_valid},
                        {31'b0, (c >= 2) && (c % 2 == 0) && (c != 10)});
            checkOutput($sformatf("t3_if_rsp_c%0d", c), {31'b0, if_rsp_valid}, {31'b0, c == 10});
        end
        idleCycles(3);

        $display("[TB] Fetch flush");
        stepCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t4_if_ready", {31'b0, if_req_ready}, 32'h1);
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t4_flush_cyc1_rsp", {31'b0, if_rsp_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b1, 12'h014, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t4_killed_rsp", {31'b0, if_rsp_valid}, 32'h0);
        checkOutput("t4_new_ready", {31'b0, if_req_ready}, 32'h1);
        idleCycles(2);
        checkOutput("t4_new_rsp", {31'b0, if_rsp_valid}, 32'h1);
        checkOutput("t4_new_data", if_rsp_data, 32'h00100113);
        idleCycles(2);

        $display("[TB] Store then load");
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b1, 12'h200, 1'b1, 32'h0000000A, 4'hF);
        checkOutput("t5_dm_ready", {31'b0, dm_req_ready}, 32'h1);
        checkOutput("t5_mem_we", {31'b0, mem_we}, 32'h1);
        checkOutput("t5_mem_wdata", mem_wdata, 32'h0000000A);
        checkOutput("t5_mem_be", {28'b0, mem_be}, 32'hF);
        checkOutput("t5_mem_addr", {20'b0, mem_addr}, 32'h200);
        idleCycles(1);
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b1, 12'h200, 1'b0, 32'h0, 4'h0);
        checkOutput("t5_st_rsp", {31'b0, dm_rsp_valid}, 32'h1);
        checkOutput("t5_st_rdata", dm_rsp_rdata, 32'h0);
        checkOutput("t5_ld_ready", {31'b0, dm_req_ready}, 32'h1);
        checkOutput("t5_ld_we", {31'b0, mem_we}, 32'h0);
        idleCycles(2);
        checkOutput("t5_ld_rsp", {31'b0, dm_rsp_valid}, 32'h1);
        checkOutput("t5_ld_rdata", dm_rsp_rdata, 32'h0000000A);
        idleCycles(2);

        $display("[TB] Reset mid-transaction");
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b1, 12'h100, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_dm_ready", {31'b0, dm_req_ready}, 32'h1);
        stepCycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b1, 12'h100, 1'b0, 32'h0, 4'h0);
        checkAllZero("t6_rst");
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_late_rsp", {31'b0, dm_rsp_valid}, 32'h0);
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_post_dm_rsp", {31'b0, dm_rsp_valid}, 32'h0);
        checkOutput("t6_post_if_ready", {31'b0, if_req_ready}, 32'h1);
        checkOutput("t6_post_mem_addr", {20'b0, mem_addr}, 32'h010);
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_no_dm_rsp", {31'b0, dm_rsp_valid}, 32'h0);
        stepCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t6_if_rsp", {31'b0, if_rsp_valid}, 32'h1);
        checkOutput("t6_if_data", if_rsp_data, 32'h00A00093);
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
